md_sequencer: RTL and testbench

//  Iterative multiply/divide controller for MULT/MULTU/DIV/DIVU.
//  - Sequences a radix-2 shift-add multiplier and a restoring divider over WIDTH steps.
//  - Owns the HI/LO result registers.
//  - Drives the busy stall that holds the PC and the IR while an operation is in flight.
//  - Sits beside the ALU; the control unit drives start/op, and rs/rt feed a/b.

---
 rtl/md_pkg.sv | 37 +++
 rtl/md_sequencer_if.sv | 33 +++
 rtl/md_step.sv | 41 ++++
 rtl/md_sequencer.sv | 149 ++++++++++++++
 tb/tb_md_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
//   Shared types and constants for the iterative multiply/divide sequencer.
//   - MD_WIDTH / ITERS : default operand width and number of RUN iterations
//   - md_op_e          : MULT / MULTU / DIV / DIVU opcode encoding
//   - md_state_e       : sequencer FSM states
//   - is_signed_op / is_div_op : opcode classification helpers
// ---------------------------------------------------------------------------
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam int ITERS    = MD_WIDTH;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } md_state_e;

  function automatic logic is_signed_op(input md_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_sequencer_if.sv
// ---------------------------------------------------------------------------
// md_sequencer_if
//   Issue/result bundle between the control unit (master) and the
//   multiply/divide sequencer (slave).
//   master -> slave : start, op[1:0], a[WIDTH-1:0], b[WIDTH-1:0]
//   slave -> master : busy, done, div_zero, hi[WIDTH-1:0], lo[WIDTH-1:0]
// ---------------------------------------------------------------------------
interface md_sequencer_if
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/md_step.sv
// ---------------------------------------------------------------------------
// md_step
//   One combinational iteration of the multiply/divide datapath.
//   i_div_mode : 0 = shift-add multiply step, 1 = restoring divide step
//   i_acc      : 2*WIDTH working pair
//                mul: {partial product high, multiplier / product low}
//                div: {partial remainder, dividend / quotient}
//   i_opnd     : multiplicand (mul) or divisor (div)
//   o_acc      : working pair after this iteration
// ---------------------------------------------------------------------------
module md_step
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               i_div_mode,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_new;

  // Multiply: the carry of the add becomes the new MSB after the right shift.
  assign w_mul_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} +
                     (i_acc[0] ? {1'b0, i_opnd} : '0);

  // Divide: the left-shifted remainder needs WIDTH+1 bits, since the bit
  // shifted out of the top may be set.  The trial result never exceeds
  // WIDTH bits when it is non-negative because remainder < divisor.
  assign w_trial   = i_acc[2*WIDTH-1:WIDTH-1] - {1'b0, i_opnd};
  assign w_qbit    = ~w_trial[WIDTH];
  assign w_rem_new = w_qbit ? w_trial[WIDTH-1:0] : i_acc[2*WIDTH-2:WIDTH-1];

  assign o_acc = i_div_mode ? {w_rem_new, i_acc[WIDTH-2:0], w_qbit}
                            : {w_mul_sum, i_acc[WIDTH-1:1]};

endmodule

// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//   Iterative MULT/MULTU/DIV/DIVU controller owning the HI/LO registers.
//   Sequence: IDLE -> PREP (magnitudes/signs) -> RUN (WIDTH steps)
//             -> FIX (sign correction, HI/LO write) -> DONE -> IDLE.
//   i_clk : system clock, rising edge
//   i_rst : asynchronous, active-low reset
//   bus   : md_sequencer_if.slave (start/op/a/b in; busy/done/div_zero/hi/lo out)
// ---------------------------------------------------------------------------
module md_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic           i_clk,
  input  logic           i_rst,
  md_sequencer_if.slave  bus
);

  md_state_e          r_state;
  logic [CNT_W-1:0]   r_cnt;
  md_op_e             r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_sign_a;
  logic               r_sign_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_div_zero;

  logic               w_signed;
  logic               w_div;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_b_zero;

  assign w_signed = is_signed_op(r_op);
  assign w_div    = is_div_op(r_op);
  assign w_neg_a  = w_signed & r_a[WIDTH-1];
  assign w_neg_b  = w_signed & r_b[WIDTH-1];
  assign w_abs_a  = w_neg_a ? -r_a : r_a;
  assign w_abs_b  = w_neg_b ? -r_b : r_b;

  md_step #(.WIDTH(WIDTH)) u_step (
    .i_div_mode (w_div),
    .i_acc      (r_acc),
    .i_opnd     (r_opnd),
    .o_acc      (w_acc_next)
  );

  // Sign correction on the unsigned magnitude result.  Negating the most
  // negative quotient wraps back onto itself, which is the intended
  // modular result for 0x80000000 / -1.
  assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
  assign w_quo_fix  = (r_sign_a ^ r_sign_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem_fix  = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_b_zero   = (r_b == '0);

  // The issuing cycle already stalls; DONE lets the next instruction go.
  assign bus.busy = (bus.start & ((r_state == S_IDLE) | (r_state == S_DONE))) |
                    (r_state == S_PREP) | (r_state == S_RUN) | (r_state == S_FIX);
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_op       <= OP_MULT;
      r_a        <= '0;
      r_b        <= '0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_op    <= md_op_e'(bus.op);
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_state <= S_PREP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PREP: begin
          r_sign_a <= w_neg_a;
          r_sign_b <= w_neg_b;
          r_cnt    <= '0;
          if (w_div) begin
            r_acc  <= {{WIDTH{1'b0}}, w_abs_a};
            r_opnd <= w_abs_b;
          end else begin
            r_acc  <= {{WIDTH{1'b0}}, w_abs_b};
            r_opnd <= w_abs_a;
          end
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (w_div) begin
            if (w_b_zero) begin
              // Divide by zero still runs full latency; HI returns the
              // dividend as issued, not its magnitude.
              r_hi       <= r_a;
              r_lo       <= '1;
              r_div_zero <= 1'b1;
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer
//   Self-checking bench for md_sequencer: directed vector table, hand-written
//   multi-cycle sequences (ignored start, back-to-back, async reset mid-run)
//   and randomized operations checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_md_sequencer;
  import md_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  md_sequencer_if #(.WIDTH(32)) bus ();

  md_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'h0, a} * {32'h0, b}; hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
        end else if (op == 2'b11) begin
          lo = a / b; hi = a % b;
        end else begin
          sq = sa / sb; sr = sa % sb;
          lo = sq[31:0]; hi = sr[31:0];
        end
      end
    endcase
  endfunction

  // Idle cycles: nothing may pulse and HI/LO must hold.
  task automatic idle(input int k);
    logic [63:0] held;
    held = {bus.hi, bus.lo};
    repeat (k) begin
      @(posedge clk); #1;
      chk("idle_done", bus.done, 1'b0);
      chk("idle_dz", bus.div_zero, 1'b0);
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_hold", {bus.hi, bus.lo}, held);
    end
  endtask

  // Issue one operation from the current cycle (IDLE or DONE) and wait for
  // done.  poke_n > 0 re-asserts start with other operands mid-operation.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_n, output logic [31:0] hi, output logic [31:0] lo,
                        output logic dz);
    logic [63:0] prev;
    int          lat;
    prev = {bus.hi, bus.lo};
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    #1;
    chk("busy_issue", bus.busy, 1'b1);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.op = 2'($urandom);
    chk("done_clear", bus.done, 1'b0);
    chk("busy_prep", bus.busy, 1'b1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == poke_n) begin
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'hDEAD_BEEF; bus.b = 32'h3;
      end else if (n == poke_n + 1) begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      chk("busy_run", bus.busy, 1'b1);
      chk("dz_low", bus.div_zero, 1'b0);
      chk("no_partial", {bus.hi, bus.lo}, prev);
    end
    bus.start = 1'b0;
    chk("latency", 64'(lat), 64'd34);
    chk("busy_done", bus.busy, 1'b0);
    hi = bus.hi; lo = bus.lo; dz = bus.div_zero;
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h div_zero=%0d latency=%0d", op, a, b, hi, lo, dz, lat);
  endtask

  initial begin
    logic [31:0] hi, lo, ehi, elo, ra, rb;
    logic        dz, edz;
    logic [1:0]  rop;

    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;

    vecs[0] = '{"multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{"mult_neg",   2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{"div_neg",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{"divu_small", 2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0};
    vecs[4] = '{"divu_zero",  2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{"div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{"div_zero_s", 2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{"mult_min",   2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[8] = '{"div_negb",   2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[9] = '{"multu_zero", 2'b01, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_dz", bus.div_zero, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table; odd entries issue back-to-back from DONE
    foreach (vecs[i]) begin
      if (i % 2 == 0) idle(1);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, hi, lo, dz);
      chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      chk({vecs[i].name, "_dz"}, dz, vecs[i].exp_dz);
    end
    idle(2);

    // start re-asserted during RUN is ignored; then back-to-back from DONE
    run_op(2'b01, 32'h0000_1000, 32'h0000_0020, 10, hi, lo, dz);
    chk("ignore_hi", hi, 32'h0);
    chk("ignore_lo", lo, 32'h0002_0000);
    run_op(2'b11, 32'd100, 32'd7, 0, hi, lo, dz);
    chk("b2b_hi", hi, 32'd2);
    chk("b2b_lo", lo, 32'd14);
    idle(2);

    // Asynchronous reset while RUN is at counter 10
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'h0000_FFFF; bus.b = 32'h0000_FFFF;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_hi", bus.hi, 32'h0);
    chk("arst_lo", bus.lo, 32'h0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    run_op(2'b01, 32'd6, 32'd7, 0, hi, lo, dz);
    chk("post_rst_lo", lo, 32'd42);
    chk("post_rst_hi", hi, 32'd0);

    // Randomized operations against the reference model
    for (int t = 0; t < 40; t++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'($urandom_range(1, 15)) ^ 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      idle($urandom_range(0, 2));
      run_op(rop, ra, rb, 0, hi, lo, dz);
      model(rop, ra, rb, ehi, elo, edz);
      chk("rand_hi", hi, ehi);
      chk("rand_lo", lo, elo);
      chk("rand_dz", dz, edz);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
